// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the FIFO controller and its register file.
package fifo_ctrl_pkg;

  // Default address width; depth is 2**FIFO_N entries.
  localparam int FIFO_N = 2;

  // Data width of the register file sitting downstream of the controller.
  localparam int BITS = 4;

  // Qualified operation in a given cycle, encoded as {do_wr, do_rd}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // Number of entries for a given address width.
  function automatic int fifo_depth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a FIFO user (master) and the controller (slave).
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int N = FIFO_N
) ();

  logic         wr;
  logic         rd;
  logic         err_clr;
  logic [N-1:0] address_w;
  logic [N-1:0] address_r;
  logic         WE;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [N:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output wr, rd, err_clr,
    input  address_w, address_r, WE, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, rd, err_clr,
    output address_w, address_r, WE, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ctrl_ptr_counter.sv
// N-bit wrapping pointer with async reset and increment enable.
module ptr_counter #(
  parameter int N = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         en,
  output logic [N-1:0] value
);

  // Advance by one when enabled; natural N-bit overflow gives the wrap.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      value <= '0;
    end else if (en) begin
      value <= value + N'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Circular-FIFO control for a 2**N x BITS register file: pointers, occupancy,
// status flags and sticky error flags. Read data stays in the register file.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int N        = FIFO_N,
  parameter int AF_LEVEL = (2 ** N) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  fifo_ctrl_if.slave bus
);

  localparam int         DEPTH   = fifo_depth(N);
  localparam logic [N:0] DEPTH_C = (N+1)'(DEPTH);
  localparam logic [N:0] AF_C    = (N+1)'(AF_LEVEL);
  localparam logic [N:0] AE_C    = (N+1)'(AE_LEVEL);

  logic [N-1:0] wptr;
  logic [N-1:0] rptr;
  logic [N:0]   count;
  logic         overflow;
  logic         underflow;
  logic         full;
  logic         empty;
  logic         do_wr;
  logic         do_rd;
  logic         ov_evt;
  logic         un_evt;
  op_e          op;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A push into a full FIFO is allowed when a pop frees the head slot in the
  // same cycle; the head is read before the edge and overwritten at it.
  assign do_wr  = bus.wr & (~full | bus.rd);
  assign do_rd  = bus.rd & ~empty;
  assign ov_evt = bus.wr & ~do_wr;
  assign un_evt = bus.rd & ~do_rd;
  assign op     = op_e'({do_wr, do_rd});

  ptr_counter #(.N(N)) u_wptr (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (do_wr),
    .value (wptr)
  );

  ptr_counter #(.N(N)) u_rptr (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (do_rd),
    .value (rptr)
  );

  // Occupancy tracks accepted pushes minus accepted pops; never leaves 0..DEPTH.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + (N+1)'(1);
        OP_POP:  count <= count - (N+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new dropped request outranks a simultaneous clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ov_evt | (overflow  & ~bus.err_clr);
      underflow <= un_evt | (underflow & ~bus.err_clr);
    end
  end

  assign bus.address_w    = wptr;
  assign bus.address_r    = rptr;
  assign bus.WE           = do_wr & ~RESET;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural register file attached.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int N = FIFO_N;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [3:0] dw;
    logic       e_we;
    logic [1:0] e_aw;
    logic [1:0] e_ar;
    logic       chk_d;
    logic [3:0] e_dr;
    logic [2:0] e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_af;
    logic       e_ae;
    logic       e_ov;
    logic       e_un;
  } vec_t;

  logic            CLK;
  logic            RESET;
  logic [BITS-1:0] data_w;
  logic [BITS-1:0] data_r;
  logic [BITS-1:0] mem [4];

  int n_checks;
  int n_fail;
  vec_t vq[$];

  fifo_ctrl_if #(.N(N)) bus ();

  fifo_ctrl #(.N(N)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  // Register file model: written on the edge, read combinationally.
  always @(posedge CLK) begin
    if (bus.WE) mem[bus.address_w] <= data_w;
  end
  assign data_r = mem[bus.address_r];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic clr,
                     input logic [3:0] dw, input logic we, input logic [1:0] aw,
                     input logic [1:0] ar, input logic cd, input logic [3:0] dr,
                     input logic [2:0] cnt, input logic fu, input logic em,
                     input logic af, input logic ae, input logic ov,
                     input logic un);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.dw = dw;
    v.e_we = we; v.e_aw = aw; v.e_ar = ar; v.chk_d = cd; v.e_dr = dr;
    v.e_cnt = cnt; v.e_full = fu; v.e_empty = em; v.e_af = af; v.e_ae = ae;
    v.e_ov = ov; v.e_un = un;
    vq.push_back(v);
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge CLK);
    bus.wr = v.wr; bus.rd = v.rd; bus.err_clr = v.clr; data_w = v.dw;
    #1;
    chk("WE", idx, 8'(bus.WE), 8'(v.e_we));
    chk("address_w", idx, 8'(bus.address_w), 8'(v.e_aw));
    chk("address_r", idx, 8'(bus.address_r), 8'(v.e_ar));
    if (v.chk_d) chk("data_r", idx, 8'(data_r), 8'(v.e_dr));
    @(posedge CLK);
    #1;
    chk("count", idx, 8'(bus.count), 8'(v.e_cnt));
    chk("full", idx, 8'(bus.full), 8'(v.e_full));
    chk("empty", idx, 8'(bus.empty), 8'(v.e_empty));
    chk("almost_full", idx, 8'(bus.almost_full), 8'(v.e_af));
    chk("almost_empty", idx, 8'(bus.almost_empty), 8'(v.e_ae));
    chk("overflow", idx, 8'(bus.overflow), 8'(v.e_ov));
    chk("underflow", idx, 8'(bus.underflow), 8'(v.e_un));
  endtask

  initial begin
    int p;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    //  wr rd clr dw    we aw ar chk dr    cnt full emp af ae ov un
    // Fill
    add(1, 0, 0, 4'd1, 1, 0, 0, 0, 4'd0, 3'd1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 4'd2, 1, 1, 0, 0, 4'd0, 3'd2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4'd3, 1, 2, 0, 0, 4'd0, 3'd3, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 4'd4, 1, 3, 0, 0, 4'd0, 3'd4, 1, 0, 1, 0, 0, 0);
    // Overflow and clear priority
    add(1, 0, 0, 4'd5, 0, 0, 0, 0, 4'd0, 3'd4, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 4'd0, 0, 0, 0, 0, 4'd0, 3'd4, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 4'd6, 0, 0, 0, 0, 4'd0, 3'd4, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 4'd0, 0, 0, 0, 0, 4'd0, 3'd4, 1, 0, 1, 0, 0, 0);
    // Drain, then underflow
    add(0, 1, 0, 4'd0, 0, 0, 0, 1, 4'd1, 3'd3, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 4'd0, 0, 0, 1, 1, 4'd2, 3'd2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd0, 0, 0, 2, 1, 4'd3, 3'd1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 4'd0, 0, 0, 3, 1, 4'd4, 3'd0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 4'd0, 0, 0, 0, 0, 4'd0, 3'd0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 1, 4'd0, 0, 0, 0, 0, 4'd0, 3'd0, 0, 1, 0, 1, 0, 0);
    // Refill, then push+pop at full overwrites the head slot
    add(1, 0, 0, 4'd7, 1, 0, 0, 0, 4'd0, 3'd1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 4'd8, 1, 1, 0, 0, 4'd0, 3'd2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4'd9, 1, 2, 0, 0, 4'd0, 3'd3, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 4'd10, 1, 3, 0, 0, 4'd0, 3'd4, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 4'd11, 1, 0, 0, 1, 4'd7, 3'd4, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 4'd0, 0, 1, 1, 1, 4'd8, 3'd3, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 4'd0, 0, 1, 2, 1, 4'd9, 3'd2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'd0, 0, 1, 3, 1, 4'd10, 3'd1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 4'd0, 0, 1, 0, 1, 4'd11, 3'd0, 0, 1, 0, 1, 0, 0);
    // Push+pop at empty: write only, underflow
    add(1, 1, 0, 4'd12, 1, 1, 1, 0, 4'd0, 3'd1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 4'd0, 0, 2, 1, 0, 4'd0, 3'd1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 4'd0, 0, 2, 1, 1, 4'd12, 3'd0, 0, 1, 0, 1, 0, 0);
    // Wrap: 10 push/pop pairs starting with both pointers at 2
    for (int i = 0; i < 10; i++) begin
      p = (2 + i) % 4;
      add(1, 0, 0, 4'(i + 3), 1, 2'(p), 2'(p), 0, 4'd0, 3'd1, 0, 0, 0, 1, 0, 0);
      add(0, 1, 0, 4'd0, 0, 2'((p + 1) % 4), 2'(p), 1, 4'(i + 3),
          3'd0, 0, 1, 0, 1, 0, 0);
    end
    // Three entries in flight before the mid-operation reset
    add(1, 0, 0, 4'd13, 1, 0, 0, 0, 4'd0, 3'd1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 4'd14, 1, 1, 0, 0, 4'd0, 3'd2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4'd15, 1, 2, 0, 0, 4'd0, 3'd3, 0, 0, 1, 0, 0, 0);

    // Reset state, with requests asserted to show WE is held off
    RESET = 1'b1;
    bus.wr = 1'b1; bus.rd = 1'b1; bus.err_clr = 1'b0; data_w = '0;
    #12;
    chk("rst_WE", -1, 8'(bus.WE), 8'd0);
    chk("rst_count", -1, 8'(bus.count), 8'd0);
    chk("rst_empty", -1, 8'(bus.empty), 8'd1);
    chk("rst_full", -1, 8'(bus.full), 8'd0);
    chk("rst_almost_empty", -1, 8'(bus.almost_empty), 8'd1);
    chk("rst_almost_full", -1, 8'(bus.almost_full), 8'd0);
    chk("rst_address_w", -1, 8'(bus.address_w), 8'd0);
    chk("rst_address_r", -1, 8'(bus.address_r), 8'd0);
    chk("rst_overflow", -1, 8'(bus.overflow), 8'd0);
    chk("rst_underflow", -1, 8'(bus.underflow), 8'd0);
    bus.wr = 1'b0; bus.rd = 1'b0;
    RESET = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

    // Asynchronous reset pulsed between edges with count = 3
    @(negedge CLK);
    bus.wr = 1'b1; bus.rd = 1'b0; bus.err_clr = 1'b0; data_w = 4'd9;
    #1;
    chk("pre_rst_WE", -2, 8'(bus.WE), 8'd1);
    #1 RESET = 1'b1;
    #1;
    chk("mid_rst_WE", -2, 8'(bus.WE), 8'd0);
    chk("mid_rst_count", -2, 8'(bus.count), 8'd0);
    chk("mid_rst_empty", -2, 8'(bus.empty), 8'd1);
    chk("mid_rst_full", -2, 8'(bus.full), 8'd0);
    chk("mid_rst_address_w", -2, 8'(bus.address_w), 8'd0);
    chk("mid_rst_address_r", -2, 8'(bus.address_r), 8'd0);
    RESET = 1'b0;
    #1;
    chk("post_rst_WE", -2, 8'(bus.WE), 8'd1);
    @(posedge CLK);
    #1;
    chk("post_rst_count", -2, 8'(bus.count), 8'd1);
    chk("post_rst_address_w", -2, 8'(bus.address_w), 8'd1);
    chk("post_rst_data_r", -2, 8'(data_r), 8'd9);
    bus.wr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control stage directly upstream of the 2^N x BITS register file.
- Turns push/pop requests into the register file's write address, read address and write enable, so the pair forms a circular FIFO.
- Keeps head/tail pointers and occupancy count.
- Reports full/empty, programmable almost-full/almost-empty, and sticky overflow/underflow errors.
- Read data path stays in the register file: data_r shows the head entry combinationally (first-word fall-through).

Parameters:
- N, 2, address width; depth = 2**N; must equal the register file's N.
- AF_LEVEL, 2**N-1, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- wr  input  1  push request; data is presented on the register file's data_w in the same cycle.
- rd  input  1  pop request; consumes the entry currently on data_r.
- err_clr  input  1  synchronous clear of overflow and underflow.
- address_w  output  N  write pointer; drives the register file's address_w.
- address_r  output  N  read pointer; drives the register file's address_r.
- WE  output  1  write enable to the register file.
- full  output  1  count == 2**N.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  N+1  occupancy, 0..2**N.
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: a pop was dropped.

Behaviour:
- Reset (async, immediate):
  - wptr = rptr = 0, count = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0 (when AF_LEVEL > 0), address_w = address_r = 0.
  - WE forced 0 while RESET is high.
- Registered state: wptr, rptr, count, overflow, underflow.
- Combinational outputs, decoded from that state and the current wr/rd:
  - address_w, address_r, all status flags, WE.
- Qualified strobes:
  - do_wr = wr & (~full | rd).
  - do_rd = rd & ~empty.
  - WE = do_wr & ~RESET.
- Push semantics: register file captures data_w at address_w on the edge; wptr advances at the same edge.
- Pop semantics: head entry is valid on data_r during the cycle rd is high; rptr advances at the edge; next entry visible the following cycle.
- Pointers: N-bit, wrap modulo 2**N (3 -> 0 for N=2) with no special handling.
- Count update:
  - do_wr only: +1.
  - do_rd only: -1.
  - both or neither: unchanged.
- Full with wr & rd:
  - Both are performed, count stays 2**N, no overflow.
  - The head entry is read this cycle and overwritten at the edge; this is legal.
- Empty with wr & rd: write only, count -> 1, underflow sets.
- Full with wr & ~rd: push dropped, WE = 0, overflow sets.
- Empty with rd & ~wr: pop dropped, underflow sets.
- Sticky error priority:
  - A new error event in the same cycle as err_clr wins; the flag stays 1.
  - Otherwise err_clr clears the flag at the edge.
- RESET mid-operation: all state clears immediately; prior contents are abandoned (register file contents are not cleared and not reachable).
- Latency: status flags update one edge after the causing request; count is never outside 0..2**N.

Decomposition:
- Shared package/include:
  - FIFO default depth constant (N = 2).
  - Data width (BITS = 4), shared with the register file.
- One sub-module: ptr_counter, an N-bit wrapping counter with async reset and increment enable.
  - Instantiated twice (write and read pointers).
- Count logic, flags and error flags stay in fifo_ctrl.

Test Plan:
- Fill: reset, 4 consecutive pushes (N = 2) with data 1, 2, 3, 4.
  - address_w steps 0, 1, 2, 3, 0; count 1..4.
  - full = 1 after the 4th edge; almost_full = 1 from count 3.
- Overflow: 5th push while full.
  - WE = 0, count stays 4, overflow = 1.
  - err_clr alone -> overflow = 0; err_clr together with another full push -> overflow stays 1.
- Drain: 4 pops.
  - data_r reads 1, 2, 3, 4 in order; address_r wraps 3 -> 0.
  - empty = 1 after the 4th edge; a 5th pop gives underflow = 1 and count stays 0.
- Simultaneous:
  - At full, wr & rd: count stays 4, head is read, new data written to the same slot, no error.
  - At empty, wr & rd: count = 1, underflow = 1.
- Wrap: 10 alternating push/pop pairs: FIFO order is preserved across pointer wrap, count toggles 0/1, no error flags.
- Reset mid-operation: with count = 3, pulse RESET between edges.
  - count = 0, empty = 1, both pointers 0, WE = 0 immediately, without waiting for a clock edge.
